// File: rtl/mmio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mmio_bus_arbiter
//
// Shares one FPro MMIO bus between two masters. A transaction is latched in
// IDLE, strobed onto the bus for exactly one cycle in ISSUE, and acknowledged
// to the granted master in ACK. Every transaction therefore takes three
// cycles. When both masters contend, the one not granted last wins.
//
// Ports
//   clk                      system clock, all state on the rising edge
//   reset                    asynchronous, active-low reset
//   m0_* / m1_*              master request side:
//       _req                 request, held until ack
//       _wr                  1 = write, 0 = read
//       _addr / _wr_data     transaction address and write data
//       _rd_data             registered read data, held until the next read
//       _ack                 one-cycle completion pulse
//   mmio_cs/_wr/_rd          FPro bus strobes, only active in ISSUE
//   mmio_addr / _wr_data     FPro bus address and write data, zero when idle
//   mmio_rd_data             FPro bus read data, valid in the strobe cycle
//   busy                     high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,

    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic                gnt_q,        gnt_d;
    logic                last_gnt_q,   last_gnt_d;
    logic                wr_q,         wr_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
    logic [DATA_W-1:0]   rd_data0_q,   rd_data0_d;
    logic [DATA_W-1:0]   rd_data1_q,   rd_data1_d;

    logic                winner;
    logic                in_issue;

    // Round-robin pick: under contention the master not granted last wins,
    // otherwise whichever single master is requesting.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = ~last_gnt_q;
        end else begin
            winner = m1_req;
        end
    end

    // Next-state and datapath updates. The transaction is copied out of the
    // master's inputs on the IDLE->ISSUE edge so later input changes cannot
    // disturb the bus cycle in progress.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        rd_data0_d = rd_data0_q;
        rd_data1_d = rd_data1_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d      = winner;
                    last_gnt_d = winner;
                    if (winner) begin
                        wr_d      = m1_wr;
                        addr_d    = m1_addr;
                        wr_data_d = m1_wr_data;
                    end else begin
                        wr_d      = m0_wr;
                        addr_d    = m0_addr;
                        wr_data_d = m0_wr_data;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // Bus read data is only valid during the strobe cycle, so it
                // is captured here; writes leave the read registers alone.
                if (!wr_q) begin
                    if (gnt_q) begin
                        rd_data1_d = mmio_rd_data;
                    end else begin
                        rd_data0_d = mmio_rd_data;
                    end
                end
                state_d = ACK;
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The last-grant pointer resets to m1 so
    // that m0 wins the first contention after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
        end
    end

    // Bus and ack outputs decode directly from the state register, so an
    // asynchronous reset drops them in the same instant it clears the FSM.
    always_comb begin
        in_issue     = (state_q == ISSUE);
        mmio_cs      = in_issue;
        mmio_wr      = in_issue &  wr_q;
        mmio_rd      = in_issue & ~wr_q;
        mmio_addr    = in_issue ? addr_q    : '0;
        mmio_wr_data = in_issue ? wr_data_q : '0;
        m0_ack       = (state_q == ACK) & ~gnt_q;
        m1_ack       = (state_q == ACK) &  gnt_q;
        busy         = (state_q != IDLE);
        m0_rd_data   = rd_data0_q;
        m1_rd_data   = rd_data1_q;
    end

`ifndef SYNTHESIS
    // Only one master can ever be acknowledged at a time.
    ack_onehot_a : assert property (@(posedge clk) disable iff (!reset)
        !(m0_ack && m1_ack));
`endif

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_arbiter
//
// Directed checks for the two-master MMIO arbiter. Inputs change and outputs
// are sampled 1 ns after the rising edge; cycle N below means "just after the
// Nth rising edge since the stimulus was applied".
// ---------------------------------------------------------------------------
module tb_mmio_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              m0_req, m1_req, m0_wr, m1_wr;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              m0_ack, m1_ack;
    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data, mmio_rd_data;
    logic              busy;

    int check_cnt = 0;
    int pass_cnt  = 0;

    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_wr        (m0_wr),
        .m0_addr      (m0_addr),
        .m0_wr_data   (m0_wr_data),
        .m0_rd_data   (m0_rd_data),
        .m0_ack       (m0_ack),
        .m1_req       (m1_req),
        .m1_wr        (m1_wr),
        .m1_addr      (m1_addr),
        .m1_wr_data   (m1_wr_data),
        .m1_rd_data   (m1_rd_data),
        .m1_ack       (m1_ack),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
        mmio_rd_data = '0;
        step();
        step();
        check_cnt++;
        if ({busy, mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack} !== 6'b0) begin
            $display("[TB] FAIL reset_ctrl: got %b want 000000", {busy, mmio_cs, mmio_wr, mmio_rd, m0_ack, m1_ack});
        end else pass_cnt++;
        check_cnt++;
        if ({mmio_addr, mmio_wr_data, m0_rd_data, m1_rd_data} !== '0) begin
            $display("[TB] FAIL reset_data: addr=%h wd=%h rd0=%h rd1=%h want all 0", mmio_addr, mmio_wr_data, m0_rd_data, m1_rd_data);
        end else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        m0_wr = 0; m0_addr = 21'h000C0; mmio_rd_data = 32'hDEADBEEF; m0_req = 1;
        step();
        check_cnt++;
        if ({mmio_cs, mmio_rd, mmio_wr, busy} !== 4'b1101 || mmio_addr !== 21'h000C0) begin
            $display("[TB] FAIL read_strobe: cs/rd/wr/busy=%b addr=%h want 1101 000c0", {mmio_cs, mmio_rd, mmio_wr, busy}, mmio_addr);
        end else pass_cnt++;
        step();
        check_cnt++;
        if ({m0_ack, m1_ack, mmio_cs} !== 3'b100 || m0_rd_data !== 32'hDEADBEEF) begin
            $display("[TB] FAIL read_ack: ack0/ack1/cs=%b rd0=%h want 100 deadbeef", {m0_ack, m1_ack, mmio_cs}, m0_rd_data);
        end else pass_cnt++;
        m0_req = 0;
        step();
        check_cnt++;
        if ({m0_ack, busy} !== 2'b00) begin
            $display("[TB] FAIL read_done: ack0/busy=%b want 00", {m0_ack, busy});
        end else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        // Fresh reset so the last-grant pointer is back at its reset value.
        reset = 1'b0;
        step();
        reset = 1'b1;
        m0_wr = 1; m0_addr = 21'h00010; m0_wr_data = 32'h11;
        m1_wr = 1; m1_addr = 21'h00020; m1_wr_data = 32'h22;
        mmio_rd_data = 32'hFFFF0000;
        m0_req = 1; m1_req = 1;
        step();
        check_cnt++;
        if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110 || mmio_wr_data !== 32'h11 || mmio_addr !== 21'h00010) begin
            $display("[TB] FAIL sim_issue0: cs/wr/rd=%b wd=%h addr=%h want 110 11 00010", {mmio_cs, mmio_wr, mmio_rd}, mmio_wr_data, mmio_addr);
        end else pass_cnt++;
        step();
        check_cnt++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            $display("[TB] FAIL sim_ack0: ack0/ack1=%b want 10", {m0_ack, m1_ack});
        end else pass_cnt++;
        m0_req = 0;
        step();
        check_cnt++;
        if ({busy, mmio_cs, m0_ack, m1_ack} !== 4'b0000) begin
            $display("[TB] FAIL sim_gap: busy/cs/ack0/ack1=%b want 0000", {busy, mmio_cs, m0_ack, m1_ack});
        end else pass_cnt++;
        step();
        check_cnt++;
        if (mmio_cs !== 1'b1 || mmio_wr_data !== 32'h22 || mmio_addr !== 21'h00020) begin
            $display("[TB] FAIL sim_issue1: cs=%b wd=%h addr=%h want 1 22 00020", mmio_cs, mmio_wr_data, mmio_addr);
        end else pass_cnt++;
        step();
        check_cnt++;
        if ({m0_ack, m1_ack} !== 2'b01) begin
            $display("[TB] FAIL sim_ack1: ack0/ack1=%b want 01", {m0_ack, m1_ack});
        end else pass_cnt++;
        m1_req = 0;
        step();
        check_cnt++;
        if (busy !== 1'b0 || m0_rd_data !== '0 || m1_rd_data !== '0) begin
            $display("[TB] FAIL sim_end: busy=%b rd0=%h rd1=%h want 0 0 0", busy, m0_rd_data, m1_rd_data);
        end else pass_cnt++;
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        int txn = 0;
        m0_wr = 1; m0_addr = 21'h00100; m0_wr_data = 32'hA0;
        m1_wr = 1; m1_addr = 21'h00200; m1_wr_data = 32'hB1;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            check_cnt++;
            if (m0_ack && m1_ack) begin
                $display("[TB] FAIL cont_both_ack: cycle %0d both acks high", i);
            end else pass_cnt++;
            if (i % 3 == 0) begin
                check_cnt++;
                if (mmio_cs !== 1'b1 || mmio_addr !== ((txn % 2 == 0) ? 21'h00100 : 21'h00200)) begin
                    $display("[TB] FAIL cont_issue%0d: cs=%b addr=%h want 1 %h", txn, mmio_cs, mmio_addr, (txn % 2 == 0) ? 21'h00100 : 21'h00200);
                end else pass_cnt++;
            end else if (i % 3 == 1) begin
                check_cnt++;
                if ({m0_ack, m1_ack} !== ((txn % 2 == 0) ? 2'b10 : 2'b01)) begin
                    $display("[TB] FAIL cont_ack%0d: ack0/ack1=%b want %b", txn, {m0_ack, m1_ack}, (txn % 2 == 0) ? 2'b10 : 2'b01);
                end else pass_cnt++;
                if (m0_ack) n0++;
                if (m1_ack) n1++;
                txn++;
                if (txn == 10) begin
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        check_cnt++;
        if (n0 != 5 || n1 != 5 || busy !== 1'b0) begin
            $display("[TB] FAIL cont_counts: m0=%0d m1=%0d busy=%b want 5 5 0", n0, n1, busy);
        end else pass_cnt++;
    endtask

    task automatic test_req_drop();
        int acks = 0;
        m1_wr = 0; m1_addr = 21'h00300; mmio_rd_data = 32'hCAFEF00D; m1_req = 1;
        step();
        // Pull the request and scramble the inputs during the bus cycle.
        m1_req = 0; m1_addr = 21'h003FF; m1_wr = 1;
        #1;
        check_cnt++;
        if ({mmio_cs, mmio_rd, mmio_wr} !== 3'b110 || mmio_addr !== 21'h00300) begin
            $display("[TB] FAIL drop_issue: cs/rd/wr=%b addr=%h want 110 00300", {mmio_cs, mmio_rd, mmio_wr}, mmio_addr);
        end else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m1_ack) acks++;
            if (i == 0) begin
                check_cnt++;
                if ({m0_ack, m1_ack} !== 2'b01 || m1_rd_data !== 32'hCAFEF00D) begin
                    $display("[TB] FAIL drop_ack: ack0/ack1=%b rd1=%h want 01 cafef00d", {m0_ack, m1_ack}, m1_rd_data);
                end else pass_cnt++;
            end
        end
        check_cnt++;
        if (acks != 1 || busy !== 1'b0) begin
            $display("[TB] FAIL drop_count: acks=%0d busy=%b want 1 0", acks, busy);
        end else pass_cnt++;
    endtask

    task automatic test_write_then_read();
        m1_wr = 1; m1_addr = 21'h00010; m1_wr_data = 32'h55; mmio_rd_data = 32'hBADBAD00; m1_req = 1;
        step();
        check_cnt++;
        if ({mmio_cs, mmio_wr} !== 2'b11 || mmio_wr_data !== 32'h55) begin
            $display("[TB] FAIL wr_issue: cs/wr=%b wd=%h want 11 55", {mmio_cs, mmio_wr}, mmio_wr_data);
        end else pass_cnt++;
        step();
        check_cnt++;
        if (m1_ack !== 1'b1 || m1_rd_data !== 32'hCAFEF00D) begin
            $display("[TB] FAIL wr_keep: ack1=%b rd1=%h want 1 cafef00d", m1_ack, m1_rd_data);
        end else pass_cnt++;
        m1_req = 0;
        step();
        m1_wr = 0; mmio_rd_data = 32'h12345678; m1_req = 1;
        step();
        step();
        check_cnt++;
        if (m1_ack !== 1'b1 || m1_rd_data !== 32'h12345678 || m0_rd_data !== '0) begin
            $display("[TB] FAIL rd_update: ack1=%b rd1=%h rd0=%h want 1 12345678 0", m1_ack, m1_rd_data, m0_rd_data);
        end else pass_cnt++;
        m1_req = 0;
        step();
    endtask

    task automatic test_reset_during_issue();
        m1_wr = 0; m1_addr = 21'h00040; mmio_rd_data = 32'h77777777; m1_req = 1;
        step();
        check_cnt++;
        if (mmio_cs !== 1'b1) begin
            $display("[TB] FAIL rst_pre: cs=%b want 1", mmio_cs);
        end else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        check_cnt++;
        if ({mmio_cs, mmio_rd, busy, m1_ack} !== 4'b0000 || mmio_addr !== '0 || m1_rd_data !== '0) begin
            $display("[TB] FAIL rst_async: cs/rd/busy/ack1=%b addr=%h rd1=%h want 0000 0 0", {mmio_cs, mmio_rd, busy, m1_ack}, mmio_addr, m1_rd_data);
        end else pass_cnt++;
        m1_req = 0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_cnt++;
            if ({m0_ack, m1_ack, busy} !== 3'b000) begin
                $display("[TB] FAIL rst_noack%0d: ack0/ack1/busy=%b want 000", i, {m0_ack, m1_ack, busy});
            end else pass_cnt++;
        end
        m0_wr = 1; m0_addr = 21'h00100; m1_wr = 1; m1_addr = 21'h00200;
        m0_req = 1; m1_req = 1;
        step();
        check_cnt++;
        if (mmio_cs !== 1'b1 || mmio_addr !== 21'h00100) begin
            $display("[TB] FAIL rst_regrant: cs=%b addr=%h want 1 00100", mmio_cs, mmio_addr);
        end else pass_cnt++;
        step();
        check_cnt++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            $display("[TB] FAIL rst_regrant_ack: ack0/ack1=%b want 10", {m0_ack, m1_ack});
        end else pass_cnt++;
        m0_req = 0; m1_req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_contention();
        test_req_drop();
        test_write_then_read();
        test_reset_during_issue();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
